// File: rtl/interrupt_request_sender.sv
// Converts the level interrupt from the global slave into one req/ack handshake
// per assertion, with ack timeout, re-arm on level clear and a holdoff gap.
module interrupt_request_sender #(
  parameter int SRC_WIDTH   = 64,
  parameter int CTX_WIDTH   = 9,
  parameter int ACK_TIMEOUT = 1024,
  parameter int HOLDOFF     = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_interrupt,
  input  logic [SRC_WIDTH-1:0]   i_interrupt_src,
  input  logic [CTX_WIDTH-1:0]   i_interrupt_ctx,
  input  logic                   i_interrupt_ack,
  output logic                   o_interrupt_req,
  output logic [SRC_WIDTH-1:0]   o_interrupt_src,
  output logic [CTX_WIDTH-1:0]   o_interrupt_ctx,
  output logic                   o_busy,
  output logic                   o_ack_timeout,
  output logic [COUNT_WIDTH-1:0] o_irq_count
);

  // One timer serves both the ack timeout in REQ and the gap in HOLDOFF.
  localparam int HOLD_EFF = (HOLDOFF < 1) ? 1 : HOLDOFF;
  localparam int TMAX     = (ACK_TIMEOUT > HOLD_EFF) ? ACK_TIMEOUT : HOLD_EFF;
  localparam int TW       = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] HO_LAST = TW'(HOLD_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_CLEAR,
    S_HOLDOFF
  } state_t;

  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic                   r_req;
  logic [SRC_WIDTH-1:0]   r_src;
  logic [CTX_WIDTH-1:0]   r_ctx;
  logic                   r_busy;
  logic                   r_timeout;
  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_req     <= 1'b0;
      r_src     <= '0;
      r_ctx     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_interrupt) begin
            r_src   <= i_interrupt_src;
            r_ctx   <= i_interrupt_ctx;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_state <= S_REQ;
          end
        end
        // Ack takes priority over a timeout expiring on the same edge.
        S_REQ: begin
          if (i_interrupt_ack) begin
            r_req   <= 1'b0;
            r_count <= r_count + COUNT_WIDTH'(1);
            r_state <= S_WAIT_CLEAR;
          end else if ((ACK_TIMEOUT != 0) && (r_timer == TO_LAST)) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_HOLDOFF;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_CLEAR: begin
          if (!i_interrupt) begin
            r_timer <= '0;
            r_state <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (r_timer == HO_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_interrupt_req = r_req;
  assign o_interrupt_src = r_src;
  assign o_interrupt_ctx = r_ctx;
  assign o_busy          = r_busy;
  assign o_ack_timeout   = r_timeout;
  assign o_irq_count     = r_count;

endmodule

// File: tb/tb_interrupt_request_sender.sv
// Random and directed stimulus for interrupt_request_sender, checked every cycle
// against a timeline model expressed in absolute edge numbers.
module tb_interrupt_request_sender;

  localparam int AT = 8;
  localparam int HO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_interrupt;
  logic [63:0] i_interrupt_src;
  logic [8:0]  i_interrupt_ctx;
  logic        i_interrupt_ack;
  logic        o_interrupt_req;
  logic [63:0] o_interrupt_src;
  logic [8:0]  o_interrupt_ctx;
  logic        o_busy;
  logic        o_ack_timeout;
  logic [15:0] o_irq_count;

  interrupt_request_sender #(
    .SRC_WIDTH(64), .CTX_WIDTH(9), .ACK_TIMEOUT(AT), .HOLDOFF(HO), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_interrupt(i_interrupt),
    .i_interrupt_src(i_interrupt_src),
    .i_interrupt_ctx(i_interrupt_ctx),
    .i_interrupt_ack(i_interrupt_ack),
    .o_interrupt_req(o_interrupt_req),
    .o_interrupt_src(o_interrupt_src),
    .o_interrupt_ctx(o_interrupt_ctx),
    .o_busy(o_busy),
    .o_ack_timeout(o_ack_timeout),
    .o_irq_count(o_irq_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: a pending request ages per edge; re-arming is an absolute edge number.
  int          cyc = 0;
  bit          mReq, mNeedClear, mTimeout, mBusy;
  int          mAge, mArm;
  logic [63:0] mSrc;
  logic [8:0]  mCtx;
  logic [15:0] mCount;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    mReq = 0; mNeedClear = 0; mTimeout = 0; mBusy = 0;
    mAge = 0; mArm = 0; mSrc = '0; mCtx = '0; mCount = '0;
  endtask

  task automatic modelEdge(input bit intr, input bit ack, input logic [63:0] src, input logic [8:0] ctx);
    if (mReq) begin
      mAge++;
      if (ack) begin
        mReq = 0; mCount = mCount + 16'd1; mNeedClear = 1;
      end else if (mAge == AT) begin
        mReq = 0; mTimeout = 1; mArm = cyc + HO + 1;
      end
    end else if (mNeedClear) begin
      if (!intr) begin
        mNeedClear = 0; mArm = cyc + HO + 1;
      end
    end else if (cyc >= mArm && intr) begin
      mReq = 1; mAge = 0; mSrc = src; mCtx = ctx;
    end
    mBusy = mReq || mNeedClear || (cyc + 1 < mArm);
  endtask

  task automatic checkAll();
    checkOutput("req", {63'd0, o_interrupt_req}, {63'd0, mReq});
    checkOutput("src", o_interrupt_src, mSrc);
    checkOutput("ctx", {55'd0, o_interrupt_ctx}, {55'd0, mCtx});
    checkOutput("busy", {63'd0, o_busy}, {63'd0, mBusy});
    checkOutput("timeout", {63'd0, o_ack_timeout}, {63'd0, mTimeout});
    checkOutput("count", {48'd0, o_irq_count}, {48'd0, mCount});
  endtask

  // Inputs change 1ns after an edge, so they are stable at the next edge.
  task automatic applyStimulus(input bit intr, input bit ack, input logic [63:0] src, input logic [8:0] ctx);
    i_interrupt = intr; i_interrupt_ack = ack;
    i_interrupt_src = src; i_interrupt_ctx = ctx;
    @(posedge clk);
    modelEdge(intr, ack, src, ctx);
    cyc++;
    #1 checkAll();
  endtask

  task automatic midCycleReset();
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_req", {63'd0, o_interrupt_req}, 64'd0);
    checkOutput("rst_busy", {63'd0, o_busy}, 64'd0);
    checkOutput("rst_count", {48'd0, o_irq_count}, 64'd0);
    checkAll();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_interrupt = 0; i_interrupt_ack = 0; i_interrupt_src = '0; i_interrupt_ctx = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkAll();
    #2 rst = 1'b0;

    // Basic delivery, ack 3 cycles after req, then long high level with no refire.
    repeat (9) applyStimulus(0, 0, 64'h0, 9'h0);
    applyStimulus(1, 0, 64'h1000, 9'h5);
    repeat (2) applyStimulus(1, 0, 64'h2000, 9'h7);
    applyStimulus(1, 1, 64'h2000, 9'h7);
    repeat (200) applyStimulus(1, 0, 64'h3000, 9'h9);
    repeat (6) applyStimulus(0, 0, 64'h0, 9'h0);
    applyStimulus(1, 0, 64'h4000, 9'h11);
    applyStimulus(1, 1, 64'h4000, 9'h11);
    checkOutput("count_two", {48'd0, o_irq_count}, 64'd2);
    repeat (8) applyStimulus(0, 0, 64'h0, 9'h0);

    // Timeout then retry that is acknowledged.
    repeat (14) applyStimulus(1, 0, 64'h5000, 9'h22);
    checkOutput("retry_req", {63'd0, o_interrupt_req}, 64'd1);
    applyStimulus(1, 1, 64'h5000, 9'h22);
    repeat (8) applyStimulus(0, 0, 64'h0, 9'h0);

    // Ack on the same edge the timer expires, after a fresh reset.
    midCycleReset();
    applyStimulus(1, 0, 64'h6000, 9'h33);
    repeat (7) applyStimulus(1, 0, 64'h6000, 9'h33);
    applyStimulus(1, 1, 64'h6000, 9'h33);
    checkOutput("tie_timeout", {63'd0, o_ack_timeout}, 64'd0);
    repeat (8) applyStimulus(0, 0, 64'h0, 9'h0);
    repeat (3) applyStimulus(0, 1, 64'h0, 9'h0);

    // Source changes and level drops during REQ.
    applyStimulus(1, 0, 64'h7000, 9'h44);
    repeat (3) applyStimulus(0, 0, 64'hFFFF, 9'h1FF);
    applyStimulus(0, 1, 64'hFFFF, 9'h1FF);
    repeat (7) applyStimulus(0, 0, 64'hFFFF, 9'h1FF);

    // Async reset mid-REQ, then immediate re-request.
    applyStimulus(1, 0, 64'h8000, 9'h55);
    applyStimulus(1, 0, 64'h8000, 9'h55);
    midCycleReset();
    applyStimulus(1, 0, 64'h9000, 9'h66);
    checkOutput("rerequest", {63'd0, o_interrupt_req}, 64'd1);

    // Random traffic with varying ack likelihood.
    for (int i = 0; i < 600; i++) begin
      bit intr, ack;
      intr = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 7 : 3));
      ack  = ($urandom_range(0, 7) < ((i / 100) % 2 == 0 ? 2 : 1));
      applyStimulus(intr, ack, {$urandom, $urandom}, 9'($urandom));
      if ($urandom_range(0, 199) == 0) midCycleReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_request_sender.md
Name: interrupt_request_sender

Overview:
- Consumes the level-sensitive global interrupt produced by the action's AXI-Lite global slave (o_interrupt, high while any completion mask bit is pending).
- Converts that level into a single req/ack handshake toward the host-facing SNAP interrupt interface, presenting a source address and context with each request.
- Guarantees exactly one host request per interrupt assertion. Re-arms only after software has cleared the level, then enforces a minimum gap.
- Reports a sticky error if the host never acknowledges.

Parameters:
SRC_WIDTH, 64, width of interrupt source address.
CTX_WIDTH, 9, width of interrupt context id.
ACK_TIMEOUT, 1024, max cycles req may stay high without ack; 0 disables timeout.
HOLDOFF, 4, cycles spent in HOLDOFF before re-arming (minimum 1).
COUNT_WIDTH, 16, width of delivered-interrupt counter.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
i_interrupt  in  1  level interrupt from global slave.
i_interrupt_src  in  SRC_WIDTH  source address; sampled on IDLE->REQ.
i_interrupt_ctx  in  CTX_WIDTH  context id; sampled on IDLE->REQ.
i_interrupt_ack  in  1  host acknowledge; meaningful only while o_interrupt_req=1.
o_interrupt_req  out  1  interrupt request to host.
o_interrupt_src  out  SRC_WIDTH  latched source address.
o_interrupt_ctx  out  CTX_WIDTH  latched context.
o_busy  out  1  high in any state except IDLE.
o_ack_timeout  out  1  sticky: a request timed out.
o_irq_count  out  COUNT_WIDTH  number of acknowledged requests.

Behaviour:
- Reset (async, rst=1): state=IDLE. o_interrupt_req, o_busy and o_ack_timeout go to 0. o_interrupt_src, o_interrupt_ctx and o_irq_count go to 0. Timers cleared. Reset mid-request drops req immediately, with no completion.
- All outputs are registered.
- States:
  - IDLE: if i_interrupt=1 at an edge, latch src/ctx, set o_interrupt_req=1 and go to REQ, clearing the timeout timer. Req is visible the cycle after i_interrupt is first sampled high.
  - REQ: req held high, src/ctx held stable. The timer increments each cycle.
    - If i_interrupt_ack=1 at an edge: req=0, o_irq_count+1 (wraps modulo 2^COUNT_WIDTH), go to WAIT_CLEAR.
    - Else if ACK_TIMEOUT!=0 and the timer reaches ACK_TIMEOUT-1: req=0, o_ack_timeout=1, go to HOLDOFF. The count does not change.
    - If ack and timeout occur in the same cycle, ack wins.
  - WAIT_CLEAR: wait for i_interrupt=0 sampled, then go to HOLDOFF. This prevents re-requesting while software has not yet cleared the W1C control register.
  - HOLDOFF: count HOLDOFF cycles, then go to IDLE. After a timeout, if i_interrupt is still high in IDLE, a new request (retry) is issued.
- i_interrupt dropping during REQ: req stays asserted until ack or timeout; protocol forbids withdrawing req. WAIT_CLEAR then exits on the first cycle.
- i_interrupt_ack outside REQ is ignored (no count change, no state change).
- i_interrupt toggling within WAIT_CLEAR/HOLDOFF does not generate a request. Only the level seen in IDLE matters.
- o_ack_timeout clears only on reset.
- Minimum spacing between two req rising edges is 1 (ack) + 1 (WAIT_CLEAR) + HOLDOFF + 1 (IDLE) cycles.

Test Plan:
- Basic delivery: i_interrupt=1 at cycle 10, src=64'h1000, ctx=9'h5; ack pulses 3 cycles after req rises -> req high exactly from cycle 11 until the ack edge. o_interrupt_src=64'h1000 and ctx=5 throughout. o_irq_count=1, o_busy=1 until HOLDOFF ends.
- No double fire: keep i_interrupt high for 200 cycles after ack -> no second req. Drop i_interrupt -> after HOLDOFF=4 returns to IDLE. Raise again -> second req, count=2.
- Timeout/retry: ACK_TIMEOUT=8, never ack, i_interrupt held -> req high exactly 8 cycles, then low. o_ack_timeout=1, req reasserts after HOLDOFF+1 cycles. Ack the retry -> count=1, o_ack_timeout stays 1.
- Simultaneous and stray events: ack asserted on the same edge the timer expires -> counted as ack, o_ack_timeout=0. Ack pulsed while IDLE -> count unchanged.
- Src stability and early clear: change i_interrupt_src to 64'hFFFF and drop i_interrupt during REQ -> outputs keep the latched value and req holds until ack. WAIT_CLEAR exits in 1 cycle.
- Async reset mid-REQ: assert rst between edges -> req, busy and count drop to 0 immediately. After release, with i_interrupt=1, req reasserts one cycle later.
